// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, drives the instruction memory address and captures
// the asynchronously read word into the IF/ID register, honouring stall, flush and branch.
module instruction_fetch_unit #(
    parameter int unsigned          WIDTH        = 32,
    parameter int unsigned          ADDRESS_SIZE = 10,
    parameter logic [ADDRESS_SIZE-1:0] RESET_PC  = '0,
    parameter logic [WIDTH-1:0]     NOP_INSTR    = 32'h0000_0013
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    stall,
    input  logic                    flush,
    input  logic                    branch_taken,
    input  logic [ADDRESS_SIZE-1:0] branch_target,
    output logic [ADDRESS_SIZE-1:0] imem_addr,
    output logic                    imem_read_en,
    input  logic [WIDTH-1:0]        imem_instruction,
    output logic [WIDTH-1:0]        if_id_instr,
    output logic [ADDRESS_SIZE-1:0] if_id_pc,
    output logic                    if_id_valid,
    output logic [31:0]             fetch_count
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                  state;
    logic                    running;
    logic [ADDRESS_SIZE-1:0] pc;
    logic [ADDRESS_SIZE-1:0] pc_next_seq;

    assign running      = (state == RUN);
    assign pc_next_seq  = pc + 1'b1;
    assign imem_addr    = pc;
    assign imem_read_en = running & ~stall & ~branch_taken;

    // Priority in RUN: branch > flush > stall > normal fetch. A branch never
    // waits on a stall, so a redirect cannot be lost while decode is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            if_id_instr <= NOP_INSTR;
            if_id_pc    <= '0;
            if_id_valid <= 1'b0;
            fetch_count <= '0;
        end else begin
            case (state)
                IDLE: state <= RUN;
                RUN: begin
                    if (branch_taken) begin
                        pc          <= branch_target;
                        if_id_instr <= NOP_INSTR;
                        if_id_valid <= 1'b0;
                    end else if (flush) begin
                        if_id_instr <= NOP_INSTR;
                        if_id_valid <= 1'b0;
                        if (!stall) begin
                            pc <= pc_next_seq;
                        end
                    end else if (!stall) begin
                        if_id_instr <= imem_instruction;
                        if_id_pc    <= pc;
                        if_id_valid <= 1'b1;
                        pc          <= pc_next_seq;
                        fetch_count <= fetch_count + 32'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Fetch-stage initiator for the instruction memory. It owns the program counter and drives the memory's word address and read enable. It captures the asynchronously read instruction into the IF/ID pipeline register. It also handles stall, branch redirect and flush requests from downstream pipeline stages.

Parameters:
WIDTH, 32, instruction and IF/ID data width
ADDRESS_SIZE, 10, word-address width; PC wraps modulo 2^ADDRESS_SIZE
RESET_PC, 0, word address fetched first after reset
NOP_INSTR, 32'h0000_0013, bubble value loaded into IF/ID on reset or squash

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
stall  input  1  hazard stall from decode; hold PC and IF/ID
flush  input  1  squash IF/ID contents this cycle
branch_taken  input  1  redirect request from execute
branch_target  input  ADDRESS_SIZE  redirect word address
imem_addr  output  ADDRESS_SIZE  word address to instruction memory
imem_read_en  output  1  read enable to instruction memory
imem_instruction  input  WIDTH  asynchronous read data from instruction memory
if_id_instr  output  WIDTH  registered instruction to decode
if_id_pc  output  ADDRESS_SIZE  word address of if_id_instr
if_id_valid  output  1  if_id_instr is a real fetched instruction
fetch_count  output  32  number of instructions delivered valid into IF/ID

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values while rst_n=0 and immediately after assertion:
  - pc=RESET_PC, running=0
  - if_id_instr=NOP_INSTR, if_id_pc=0, if_id_valid=0
  - fetch_count=0
  - imem_read_en=0
- State: two-state FSM in the `running` flop.
  - IDLE (running=0): entered on reset.
  - IDLE -> RUN on the first rising edge with rst_n=1.
  - No PC update or IF/ID capture happens on that edge.
  - RUN is held until reset.
- Memory interface (combinational from registers):
  - imem_addr = pc.
  - imem_read_en = running & ~stall & ~branch_taken.
- The memory is asynchronous. The instruction at pc is sampled on the same rising edge, so fetch latency is 1 cycle: pc=A in cycle n gives if_id_instr=mem[A] and if_id_pc=A in cycle n+1.
- Per-edge priority in RUN, highest first:
  1. branch_taken=1: pc<=branch_target; IF/ID<=NOP_INSTR, valid<=0; count unchanged. This overrides stall and flush.
  2. flush=1: IF/ID<=NOP_INSTR, valid<=0. pc holds if stall=1, otherwise pc<=pc+1 and the fetched word is discarded.
  3. stall=1: pc, IF/ID and fetch_count all hold.
  4. Normal: if_id_instr<=imem_instruction, if_id_pc<=pc, valid<=1, pc<=pc+1, fetch_count<=fetch_count+1.
- Arithmetic:
  - pc+1 truncates to ADDRESS_SIZE bits; 2^ADDRESS_SIZE-1 wraps to 0 with no flag.
  - fetch_count wraps at 2^32.
  - branch_target is used as-is, with no alignment check.
- Reset mid-operation: all flops return to reset values immediately, without waiting for clk. An in-flight fetch is lost. After release, fetching restarts from RESET_PC after one IDLE cycle.
- Stall and branch in the same cycle: the branch wins. The redirect must not be lost while decode is stalled.

Test Plan:
- Reset release, no stall/branch, memory preloaded mem[i]=i+0x100:
  - Cycle 1 after release is IDLE, with read_en=0 and valid=0.
  - Then if_id_instr follows 0x100, 0x101, 0x102… with if_id_pc 0,1,2…
  - fetch_count increments by 1 per cycle.
- stall held high 3 cycles at pc=5:
  - imem_read_en=0.
  - pc stays 5; if_id_instr, if_id_pc and fetch_count frozen.
  - On release, the next capture is mem[5] with if_id_pc=5.
- branch_taken=1 with branch_target=0x3F0 at pc=7, with and without stall=1:
  - Next cycle: valid=0, if_id_instr=0x00000013, pc=0x3F0.
  - Following cycle: if_id_instr=mem[0x3F0], if_id_pc=0x3F0.
- Branch to 0x3FE, then free-run: if_id_pc sequence is 0x3FE, 0x3FF, 0x000, 0x001; the wrap is seamless.
- flush=1 for one cycle at pc=9, no stall:
  - IF/ID becomes a NOP bubble, valid=0.
  - pc advances to 10; fetch_count unchanged that cycle.
- rst_n pulsed low mid-cycle while pc=0x020 and fetch_count=32:
  - Outputs go to reset values asynchronously, before the next clk edge.
  - After release: one IDLE cycle, then a fetch from RESET_PC.
